mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit_pkg.sv | 39 +++
 rtl/mem_load_ext.sv | 19 +
 rtl/mem_access_unit.sv | 117 +++++++++++
 tb/tb_mem_access_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the MEM-stage load/store unit: opcodes, func3 codes,
// FSM encodings and the byte-port request bundle.
package mem_access_unit_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int CTRL_BUS     = 6;
    localparam int STALL_MEM    = 4;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] MEM_IDLE   = 2'd0;
    localparam logic [1:0] MEM_ACCESS = 2'd1;
    localparam logic [1:0] MEM_DONE   = 2'd2;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [7:0]  dout;
    } byte_req_t;

    // Index of the final byte; undefined widths fall back to a full word.
    function automatic logic [1:0] last_byte(input logic [2:0] func3);
        case (func3[1:0])
            F3_LB[1:0]: return 2'd0;
            F3_LH[1:0]: return 2'd1;
            default:    return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Extends the assembled load buffer to 32 bits; func3[2] selects zero extension.
module mem_load_ext
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] buf_data,
    input  logic [2:0]  func3,
    output logic [31:0] ext_data
);
    logic sext;
    assign sext = ~func3[2];

    always_comb begin
        case (func3[1:0])
            F3_LB[1:0]: ext_data = {{24{sext & buf_data[7]}}, buf_data[7:0]};
            F3_LH[1:0]: ext_data = {{16{sext & buf_data[15]}}, buf_data[15:0]};
            default:    ext_data = buf_data;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: serialises LB/LH/LW/SB/SH/SW over a byte port,
// stalling the pipeline until the access completes.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CTRL_BUS-1:0]     stall_i,
    input  logic [REG_ADDR_BUS-1:0] wd_i,
    input  logic                    wreg_i,
    input  logic [REG_BUS-1:0]      wdata_i,
    input  logic [31:0]             opcode_i,
    input  logic [31:0]             func3_i,
    input  logic [31:0]             mem_addr_i,
    input  logic [31:0]             reg2_i,
    output logic [REG_ADDR_BUS-1:0] wd_o,
    output logic                    wreg_o,
    output logic [REG_BUS-1:0]      wdata_o,
    output logic                    stallreq_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [31:0]             mem_addr_o,
    output logic [7:0]              mem_dout_o,
    input  logic [7:0]              mem_din_i,
    input  logic                    mem_ack_i
);
    logic [1:0]  state;
    logic [1:0]  cnt;
    logic [1:0]  last;
    logic [31:0] load_buf;
    logic [31:0] load_val;
    logic        is_load, is_store, is_mem;
    byte_req_t   breq;
    logic        unused;

    assign unused   = ^{opcode_i[31:7], func3_i[31:3], stall_i[5], stall_i[3:0]};
    assign is_load  = (opcode_i[6:0] == OP_LOAD);
    assign is_store = (opcode_i[6:0] == OP_STORE);
    assign is_mem   = is_load | is_store;
    assign last     = last_byte(func3_i[2:0]);

    mem_load_ext u_load_ext (
        .buf_data (load_buf),
        .func3    (func3_i[2:0]),
        .ext_data (load_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MEM_IDLE;
            cnt      <= 2'd0;
            load_buf <= 32'd0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    if (is_mem) begin
                        state <= MEM_ACCESS;
                        cnt   <= 2'd0;
                    end
                end
                MEM_ACCESS: begin
                    if (mem_ack_i) begin
                        if (is_load) load_buf[{cnt, 3'b000} +: 8] <= mem_din_i;
                        if (cnt == last) state <= MEM_DONE;
                        else             cnt   <= cnt + 2'd1;
                    end
                end
                MEM_DONE: begin
                    // A held MEM stage keeps the result without touching memory again.
                    if (!stall_i[STALL_MEM]) state <= MEM_IDLE;
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

    always_comb begin
        breq       = '0;
        stallreq_o = 1'b0;
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        case (state)
            MEM_IDLE: begin
                if (is_mem) begin
                    stallreq_o = 1'b1;
                    wreg_o     = 1'b0;
                end
            end
            MEM_ACCESS: begin
                stallreq_o = 1'b1;
                wreg_o     = 1'b0;
                breq.req   = 1'b1;
                breq.we    = is_store;
                breq.addr  = mem_addr_i + {30'd0, cnt};
                breq.dout  = reg2_i[{cnt, 3'b000} +: 8];
            end
            MEM_DONE: begin
                if (is_load) wdata_o = load_val;
            end
            default: ;
        endcase
        // Outputs are forced quiet for the whole reset pulse, not just after the edge.
        if (rst) begin
            breq       = '0;
            stallreq_o = 1'b0;
            wd_o       = '0;
            wreg_o     = 1'b0;
            wdata_o    = '0;
        end
    end

    assign mem_req_o  = breq.req;
    assign mem_we_o   = breq.we;
    assign mem_addr_o = breq.addr;
    assign mem_dout_o = breq.dout;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-transfer scoreboard and writeback queue.
module tb_mem_access_unit;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i, opcode_i, func3_i, mem_addr_i, reg2_i;
    logic [4:0]  wd_o;
    logic        wreg_o, stallreq_o, mem_req_o, mem_we_o;
    logic [31:0] wdata_o, mem_addr_o;
    logic [7:0]  mem_dout_o, mem_din_i;
    logic        mem_ack_i;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .opcode_i(opcode_i), .func3_i(func3_i),
        .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .stallreq_o(stallreq_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_dout_o(mem_dout_o),
        .mem_din_i(mem_din_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  dout;
    } xfer_t;

    xfer_t       xq[$];
    logic [31:0] wbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  bmem [0:1023];
    logic        ack_en;

    assign mem_ack_i = ack_en;
    assign mem_din_i = bmem[mem_addr_o[9:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every completed byte transfer must match the next expected one.
    always @(negedge clk) begin
        if (!rst && mem_req_o && mem_ack_i) begin
            check("xfer_pending", 32'(xq.size() != 0), 32'd1);
            if (xq.size() != 0) begin
                xfer_t e;
                e = xq.pop_front();
                check("xfer_addr", mem_addr_o, e.addr);
                check("xfer_we_dout", {23'd0, mem_we_o, mem_dout_o}, {23'd0, e.we, e.dout});
            end
        end
    end

    task automatic push_xfers(input logic we, input logic [31:0] addr,
                              input logic [31:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            xfer_t e;
            e.we   = we;
            e.addr = addr + 32'(i);
            e.dout = we ? data[8*i +: 8] : 8'd0;
            xq.push_back(e);
        end
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] r2, input logic [4:0] wd, input logic wr,
                         input logic [31:0] wdat);
        int n;
        @(posedge clk); #1;
        opcode_i = {25'd0, op}; func3_i = {29'd0, f3}; mem_addr_i = addr; reg2_i = r2;
        wd_i = wd; wreg_i = wr; wdata_i = wdat;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (op == LOAD)  push_xfers(1'b0, addr, 32'd0, n);
        if (op == STORE) push_xfers(1'b1, addr, r2, n);
    endtask

    task automatic wait_done(output int stalls, input bit store_chk);
        stalls = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (store_chk) check("store_wreg", 32'(wreg_o), 32'd0);
            if (!stallreq_o) return;
            stalls++;
        end
        check("done_timeout", 32'(stallreq_o), 32'd0);
    endtask

    task automatic check_wb(input string tag, input logic [4:0] wd, input logic wr);
        logic [31:0] e;
        e = (wbq.size() != 0) ? wbq.pop_front() : 32'hxxxxxxxx;
        check({tag, "_wdata"}, wdata_o, e);
        check({tag, "_wd"}, 32'(wd_o), 32'(wd));
        check({tag, "_wreg"}, 32'(wreg_o), 32'(wr));
    endtask

    initial begin
        int st;
        for (int i = 0; i < 1024; i++) bmem[i] = 8'h00;
        bmem[10'h100] = 8'h80;
        bmem[10'h1FF] = 8'hCD; bmem[10'h200] = 8'hAB;
        bmem[10'h300] = 8'h01; bmem[10'h301] = 8'h80;
        bmem[10'h040] = 8'h11; bmem[10'h041] = 8'h22; bmem[10'h042] = 8'h33; bmem[10'h043] = 8'h44;

        // Reset with a live-looking load on the inputs: outputs must stay zero.
        rst = 1'b1; ack_en = 1'b1; stall_i = 6'd0;
        opcode_i = {25'd0, LOAD}; func3_i = 32'd2; mem_addr_i = 32'h100; reg2_i = 32'hFFFF_FFFF;
        wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'h1234;
        @(negedge clk);
        check("rst_stallreq", 32'(stallreq_o), 32'd0);
        check("rst_memreq", 32'(mem_req_o), 32'd0);
        check("rst_wreg", 32'(wreg_o), 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_wd", 32'(wd_o), 32'd0);
        opcode_i = 32'd0; func3_i = 32'd0; mem_addr_i = 32'd0; reg2_i = 32'd0;
        wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'd0;
        #2 rst = 1'b0;
        @(negedge clk);
        check("bubble_wdata", wdata_o, 32'd0);
        check("bubble_stallreq", 32'(stallreq_o), 32'd0);

        issue(ALU, 3'd0, 32'd0, 32'd0, 5'd5, 1'b1, 32'h1234);
        @(negedge clk);
        check("add_wdata", wdata_o, 32'h1234);
        check("add_wreg", 32'(wreg_o), 32'd1);
        check("add_wd", 32'(wd_o), 32'd5);
        check("add_stallreq", 32'(stallreq_o), 32'd0);
        check("add_memreq", 32'(mem_req_o), 32'd0);

        issue(LOAD, 3'b000, 32'h100, 32'd0, 5'd6, 1'b1, 32'd0);
        wbq.push_back(32'hFFFF_FF80);
        wait_done(st, 1'b0);
        check("lb_stall_cycles", 32'(st), 32'd2);
        check_wb("lb", 5'd6, 1'b1);

        issue(LOAD, 3'b100, 32'h100, 32'd0, 5'd7, 1'b1, 32'd0);
        wbq.push_back(32'h0000_0080);
        wait_done(st, 1'b0);
        check("lbu_stall_cycles", 32'(st), 32'd2);
        check_wb("lbu", 5'd7, 1'b1);

        issue(LOAD, 3'b101, 32'h1FF, 32'd0, 5'd8, 1'b1, 32'd0);
        wbq.push_back(32'h0000_ABCD);
        fork
            wait_done(st, 1'b0);
            begin
                @(posedge clk); @(posedge clk); #1 ack_en = 1'b0;
                repeat (2) @(posedge clk);
                #1 ack_en = 1'b1;
            end
        join
        check("lhu_stall_cycles", 32'(st), 32'd5);
        check_wb("lhu", 5'd8, 1'b1);

        issue(LOAD, 3'b001, 32'h300, 32'd0, 5'd9, 1'b1, 32'd0);
        wbq.push_back(32'hFFFF_8001);
        wait_done(st, 1'b0);
        check("lh_stall_cycles", 32'(st), 32'd3);
        check_wb("lh", 5'd9, 1'b1);

        issue(STORE, 3'b010, 32'h20, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'h20);
        wait_done(st, 1'b1);
        check("sw_stall_cycles", 32'(st), 32'd5);

        // LW completes, then the MEM stage is held in DONE for three cycles.
        issue(LOAD, 3'b010, 32'h40, 32'd0, 5'd10, 1'b1, 32'd0);
        wbq.push_back(32'h4433_2211);
        wait_done(st, 1'b0);
        check("lw_stall_cycles", 32'(st), 32'd5);
        check_wb("lw", 5'd10, 1'b1);
        stall_i = 6'h10;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("lw_hold_wdata", wdata_o, 32'h4433_2211);
            check("lw_hold_memreq", 32'(mem_req_o), 32'd0);
            check("lw_hold_stallreq", 32'(stallreq_o), 32'd0);
        end
        stall_i = 6'd0;
        issue(7'd0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        @(negedge clk);
        check("lw_after_memreq", 32'(mem_req_o), 32'd0);
        check("lw_after_stallreq", 32'(stallreq_o), 32'd0);

        // SW across the top of the address space, abandoned by reset after two bytes.
        issue(STORE, 3'b010, 32'hFFFF_FFFF, 32'h4455_6677, 5'd0, 1'b0, 32'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_memreq", 32'(mem_req_o), 32'd0);
        check("rst_mid_stallreq", 32'(stallreq_o), 32'd0);
        check("rst_mid_remaining", 32'(xq.size()), 32'd2);
        xq.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rerun_idle_stallreq", 32'(stallreq_o), 32'd1);
        check("rerun_idle_memreq", 32'(mem_req_o), 32'd0);
        push_xfers(1'b1, 32'hFFFF_FFFF, 32'h4455_6677, 4);
        wait_done(st, 1'b1);
        check("rerun_access_cycles", 32'(st), 32'd4);

        issue(7'd0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        @(negedge clk);
        check("xfers_all_seen", 32'(xq.size()), 32'd0);
        check("end_memreq", 32'(mem_req_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
